// File: rtl/debounce_pkg.sv
// Shared types for the multi-channel debouncer: tick edge selection and
// per-channel qualification states.
package debounce_pkg;

  typedef enum {EDGE_RISE, EDGE_FALL, EDGE_BOTH} edge_mode_e;

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_e;

  // True when a qualified transition of the given direction should tick.
  function automatic logic edge_selected(input edge_mode_e mode, input logic rising);
    if (rising) return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    else        return (mode == EDGE_FALL) || (mode == EDGE_BOTH);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: input synchroniser, stable-time qualification FSM
// with saturating counter, registered level and tick outputs.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter edge_mode_e  EDGE_MODE   = EDGE_RISE
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic sw_i,
  output logic db_level_o,
  output logic db_tick_o,
  output logic tick_nxt_o
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sw_s;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rise, fall;
  logic                   level_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
  end

  assign sw_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ZERO;
      cnt_q      <= '0;
      db_level_o <= 1'b0;
      db_tick_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_level_o <= level_d;
      db_tick_o  <= tick_nxt_o;
    end
  end

  // Disable collapses any pending qualification back to the settled state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
      case (state_q)
        WAIT1:   state_d = ZERO;
        WAIT0:   state_d = ONE;
        default: state_d = state_q;
      endcase
    end else begin
      case (state_q)
        ZERO: begin
          if (sw_s) begin
            state_d = WAIT1;
            cnt_d   = CNT_ONE;
          end
        end
        WAIT1: begin
          if (!sw_s) begin
            state_d = ZERO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ONE;
            cnt_d   = '0;
            rise    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ONE: begin
          if (!sw_s) begin
            state_d = WAIT0;
            cnt_d   = CNT_ONE;
          end
        end
        WAIT0: begin
          if (sw_s) begin
            state_d = ONE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ZERO;
            cnt_d   = '0;
            fall    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ZERO;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign level_d    = (state_d == ONE) || (state_d == WAIT0);
  assign tick_nxt_o = (rise && edge_selected(EDGE_MODE, 1'b1)) ||
                      (fall && edge_selected(EDGE_MODE, 1'b0));

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer top: independent channels plus a combined tick output
// registered in the same cycle as the per-channel ticks.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DB_CYCLES   = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter edge_mode_e  EDGE_MODE   = EDGE_RISE
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] en_i,
  input  logic [NUM_CH-1:0] sw_i,
  output logic [NUM_CH-1:0] db_level_o,
  output logic [NUM_CH-1:0] db_tick_o,
  output logic              tick_any_o
);

  logic [NUM_CH-1:0] tick_nxt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_MODE  (EDGE_MODE)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i[g]),
      .sw_i      (sw_i[g]),
      .db_level_o(db_level_o[g]),
      .db_tick_o (db_tick_o[g]),
      .tick_nxt_o(tick_nxt[g])
    );
  end

  // OR the pre-register ticks so tick_any_o lines up with db_tick_o.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) tick_any_o <= 1'b0;
    else        tick_any_o <= |tick_nxt;
  end

endmodule
